mix_columns_unit: RTL and testbench

- Registered AES MixColumns / InvMixColumns datapath for the encrypt/decrypt round pipeline.
- Accepts one 128-bit AES state per cycle.
- A mode bit selects the forward (MixColumns) or inverse (InvMixColumns) GF(2^8) column transform.
- Result is presented one clock later with a valid flag.

---
 rtl/aes_pkg.sv | 47 ++++
 rtl/mix_column_word.sv | 46 ++++
 rtl/mix_columns_unit.sv | 54 +++++
 tb/tb_mix_columns_unit.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// ============================================================================
// Module   : aes_pkg
// Brief    : Shared AES types and GF(2^8) constant multipliers.
// Revision : 1.0
// ============================================================================
`default_nettype none

package aes_pkg;

   typedef logic [127:0] state_t;
   typedef logic [31:0]  column_t;
   typedef logic [7:0]   byte_t;

   localparam byte_t AES_POLY = 8'h1b;

   function automatic byte_t xtime(input byte_t a);
      return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);
   endfunction

   function automatic byte_t gmul2(input byte_t a);
      return xtime(a);
   endfunction

   function automatic byte_t gmul3(input byte_t a);
      return xtime(a) ^ a;
   endfunction

   // Higher coefficients decompose into x8, x4 and x2 partial products.
   function automatic byte_t gmul9(input byte_t a);
      return xtime(xtime(xtime(a))) ^ a;
   endfunction

   function automatic byte_t gmulb(input byte_t a);
      return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
   endfunction

   function automatic byte_t gmuld(input byte_t a);
      return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
   endfunction

   function automatic byte_t gmule(input byte_t a);
      return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
   endfunction

endpackage : aes_pkg

`default_nettype wire

// File: rtl/mix_column_word.sv
// ============================================================================
// Module   : mix_column_word
// Brief    : Combinational MixColumns / InvMixColumns on one 32-bit column.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mix_column_word
   import aes_pkg::*;
(
   input  logic        inv,
   input  logic [31:0] col_in,
   output logic [31:0] col_out
);

   byte_t w_s0, w_s1, w_s2, w_s3;
   byte_t w_r0, w_r1, w_r2, w_r3;

   assign w_s0 = col_in[31:24];
   assign w_s1 = col_in[23:16];
   assign w_s2 = col_in[15:8];
   assign w_s3 = col_in[7:0];

   always_comb begin
      w_r0 = 8'h00;
      w_r1 = 8'h00;
      w_r2 = 8'h00;
      w_r3 = 8'h00;
      if (inv) begin
         w_r0 = gmule(w_s0) ^ gmulb(w_s1) ^ gmuld(w_s2) ^ gmul9(w_s3);
         w_r1 = gmul9(w_s0) ^ gmule(w_s1) ^ gmulb(w_s2) ^ gmuld(w_s3);
         w_r2 = gmuld(w_s0) ^ gmul9(w_s1) ^ gmule(w_s2) ^ gmulb(w_s3);
         w_r3 = gmulb(w_s0) ^ gmuld(w_s1) ^ gmul9(w_s2) ^ gmule(w_s3);
      end else begin
         w_r0 = gmul2(w_s0) ^ gmul3(w_s1) ^ w_s2        ^ w_s3;
         w_r1 = w_s0        ^ gmul2(w_s1) ^ gmul3(w_s2) ^ w_s3;
         w_r2 = w_s0        ^ w_s1        ^ gmul2(w_s2) ^ gmul3(w_s3);
         w_r3 = gmul3(w_s0) ^ w_s1        ^ w_s2        ^ gmul2(w_s3);
      end
   end

   assign col_out = {w_r0, w_r1, w_r2, w_r3};

endmodule : mix_column_word

`default_nettype wire

// File: rtl/mix_columns_unit.sv
// ============================================================================
// Module   : mix_columns_unit
// Brief    : Registered AES MixColumns / InvMixColumns, one state per cycle.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mix_columns_unit
   import aes_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   input  logic         inv,
   input  logic [127:0] data_in,
   output logic         out_valid,
   output logic [127:0] data_out
);

   localparam int C_NUM_COLS = 4;

   state_t w_mixed;
   state_t r_data_out;
   logic   r_out_valid;

   generate
      for (genvar c = 0; c < C_NUM_COLS; c++) begin : g_col
         mix_column_word u_col (
            .inv     (inv),
            .col_in  (data_in[127-32*c -: 32]),
            .col_out (w_mixed[127-32*c -: 32])
         );
      end
   endgenerate

   // data_out holds its last result across idle cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_data_out  <= '0;
      end else begin
         r_out_valid <= in_valid;
         if (in_valid) begin
            r_data_out <= w_mixed;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign data_out  = r_data_out;

endmodule : mix_columns_unit

`default_nettype wire

// File: tb/tb_mix_columns_unit.sv
// ============================================================================
// Module   : tb_mix_columns_unit
// Brief    : Self-checking bench for mix_columns_unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mix_columns_unit;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         inv;
   logic [127:0] data_in;
   logic         out_valid;
   logic [127:0] data_out;

   int total = 0;
   int bad   = 0;

   logic         m_valid;
   logic [127:0] m_data;

   mix_columns_unit dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .inv       (inv),
      .data_in   (data_in),
      .out_valid (out_valid),
      .data_out  (data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Generic shift-and-add GF(2^8) product.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      end
      return p;
   endfunction

   // Circulant matrix product: row r uses the base coefficients rotated right by r.
   function automatic logic [127:0] model_mix(input logic [127:0] st, input logic m);
      logic [7:0]   base [4];
      logic [127:0] res = '0;
      if (m) begin
         base[0] = 8'h0e; base[1] = 8'h0b; base[2] = 8'h0d; base[3] = 8'h09;
      end else begin
         base[0] = 8'h02; base[1] = 8'h03; base[2] = 8'h01; base[3] = 8'h01;
      end
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            logic [7:0] acc = 8'h00;
            for (int j = 0; j < 4; j++)
               acc ^= gf_mul(base[(j - r + 4) % 4], st[127 - 32*c - 8*j -: 8]);
            res[127 - 32*c - 8*r -: 8] = acc;
         end
      end
      return res;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference pipeline stage.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_valid <= 1'b0;
         m_data  <= '0;
      end else begin
         m_valid <= in_valid;
         if (in_valid) m_data <= model_mix(data_in, inv);
      end
   end

   always @(negedge clk) begin
      chk("cmp_valid", {127'd0, out_valid}, {127'd0, m_valid});
      chk("cmp_data", data_out, m_data);
   end

   task automatic send(input logic [127:0] d, input logic m);
      @(negedge clk);
      in_valid = 1'b1;
      data_in  = d;
      inv      = m;
      @(negedge clk);
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   localparam logic [127:0] C_A   = {4{32'h2d26314c}};
   localparam logic [127:0] C_AF  = {4{32'h4d7ebdf8}};
   localparam logic [127:0] C_B   = 128'hdb135345_f20a225c_d4d4d4d5_2d26314c;
   localparam logic [127:0] C_BF  = 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8;
   localparam logic [127:0] C_C   = 128'hd5d5d7d6_c6c6c6c6_d5d5d7d6_c6c6c6c6;
   localparam logic [127:0] C_CI  = 128'hd4d4d4d5_c6c6c6c6_d4d4d4d5_c6c6c6c6;
   localparam logic [127:0] C_P1  = {16{8'h01}};
   localparam logic [127:0] C_PC  = {16{8'hc6}};

   initial begin
      logic [127:0] x, y;
      logic         m;
      rst      = 1'b1;
      in_valid = 1'b0;
      inv      = 1'b0;
      data_in  = '0;
      #1;
      chk("reset_valid", {127'd0, out_valid}, 128'd0);
      chk("reset_data", data_out, 128'd0);

      chk("model_fwd_B", model_mix(C_B, 1'b0), C_BF);
      chk("model_inv_C", model_mix(C_C, 1'b1), C_CI);

      @(negedge clk);
      rst = 1'b0;

      send(C_A, 1'b0);  chk("fwd_A", data_out, C_AF);
      chk("fwd_A_valid", {127'd0, out_valid}, 128'd1);
      send(C_B, 1'b0);  chk("fwd_B", data_out, C_BF);
      send(C_AF, 1'b1); chk("inv_A", data_out, C_A);
      send(C_BF, 1'b1); chk("inv_B", data_out, C_B);
      send(C_C, 1'b1);  chk("inv_C", data_out, C_CI);
      send(C_P1, 1'b0); chk("fix01_fwd", data_out, C_P1);
      send(C_P1, 1'b1); chk("fix01_inv", data_out, C_P1);
      send(C_PC, 1'b0); chk("fixc6_fwd", data_out, C_PC);
      send(C_PC, 1'b1); chk("fixc6_inv", data_out, C_PC);

      // Back-to-back forward then inverse of that result.
      send(C_B, 1'b0);      chk("b2b_fwd", data_out, C_BF);
      send(data_out, 1'b1); chk("b2b_roundtrip", data_out, C_B);

      idle();
      @(negedge clk);
      chk("idle_valid", {127'd0, out_valid}, 128'd0);
      chk("idle_hold", data_out, C_B);

      // Asynchronous reset mid-stream.
      send(C_A, 1'b0);
      chk("pre_rst_valid", {127'd0, out_valid}, 128'd1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_valid", {127'd0, out_valid}, 128'd0);
      chk("async_rst_data", data_out, 128'd0);
      @(negedge clk);
      @(negedge clk);
      chk("rst_ignores_in", data_out, 128'd0);
      in_valid = 1'b0;
      rst      = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("post_rst_valid", {127'd0, out_valid}, 128'd0);
      chk("post_rst_data", data_out, 128'd0);
      send(C_B, 1'b0);
      chk("first_after_rst", data_out, C_BF);
      chk("first_after_rst_v", {127'd0, out_valid}, 128'd1);

      for (int i = 0; i < 1000; i++) begin
         x = {$urandom, $urandom, $urandom, $urandom};
         m = 1'($urandom_range(0, 1));
         send(x, m);
         send(x, 1'b0);
         y = data_out;
         send(y, 1'b1);
         chk("rand_roundtrip", data_out, x);
      end

      idle();
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_mix_columns_unit

`default_nettype wire
